data_memory_resp: RTL and testbench

DATA_MEMORY_RESP -- requirements
Module: data_memory_resp

---
 rtl/data_memory_resp.sv | 179 +++++++++++++++++
 tb/tb_data_memory_resp.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_resp.sv
`default_nettype none
// ============================================================================
//  Module   : data_memory_resp
//  Purpose  : Word-organised data memory with a fixed, programmable response
//             latency and a CPU-style request/acknowledge handshake. A request
//             is accepted from IDLE, waits LATENCY cycles and completes with a
//             one-cycle ack_o pulse. Misaligned or out-of-range accesses
//             complete with err_o and do not touch the array.
//  Ports    : clk_i   - clock, rising edge
//             rst_i   - asynchronous active-high reset
//             req_i   - access request, held until ack_o
//             we_i    - 1 = store, 0 = load
//             addr_i  - byte address
//             data_i  - store data
//             be_i    - store byte enables, be_i[0] -> bits 7:0
//             ack_o   - one-cycle completion pulse
//             data_o  - load data (0 for stores/errors), held between acks
//             err_o   - access error, qualified by ack_o
//             stall_o - CPU stall request = req_i & ~ack_o
//  Revision : 1.0 - initial release
// ============================================================================
module data_memory_resp #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  be_i,
    output logic        ack_o,
    output logic [31:0] data_o,
    output logic        err_o,
    output logic        stall_o
);

    localparam int         AW     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
    // With a single-cycle latency the access happens on the accept edge, so
    // it must use the live inputs rather than the (not yet loaded) latches.
    localparam bit         DIRECT = (LATENCY == 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] data_q;
    logic        err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          do_access;
    logic          acc_we;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_be;
    logic          acc_err;
    logic [AW-1:0] acc_idx;
    logic          mem_we;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        do_access = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    accept = 1'b1;
                    cnt_d  = LAT_M1;
                    if (DIRECT) begin
                        state_d   = S_RESP;
                        do_access = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // The edge on which the counter would reach zero performs the
                // access, so ack lands exactly LATENCY cycles after accept.
                if (cnt_q <= 4'd1) begin
                    cnt_d     = 4'd0;
                    state_d   = S_RESP;
                    do_access = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    always_comb begin
        acc_we    = DIRECT ? we_i   : we_q;
        acc_addr  = DIRECT ? addr_i : addr_q;
        acc_wdata = DIRECT ? data_i : wdata_q;
        acc_be    = DIRECT ? be_i   : be_q;
        acc_err   = (|acc_addr[1:0]) || (|acc_addr[31:AW+2]);
        acc_idx   = acc_addr[AW+1:2];
        // Reset must block a write even on the accept edge of a LATENCY=1 part.
        mem_we    = do_access && acc_we && !acc_err && !rst_i;
    end

    // ------------------------------------------------------------------
    // Control and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= we_i;
                addr_q  <= addr_i;
                wdata_q <= data_i;
                be_q    <= be_i;
            end
            if (do_access) begin
                err_q  <= acc_err;
                data_q <= (acc_err || acc_we) ? 32'd0 : mem[acc_idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory array (contents intentionally not reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ack_o   = (state_q == S_RESP);
    assign err_o   = ack_o & err_q;
    assign data_o  = data_q;
    assign stall_o = req_i & ~ack_o;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_resp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_memory_resp
//  Purpose  : Self-checking bench for data_memory_resp. Instance 0 uses
//             LATENCY=3, instance 1 uses LATENCY=1, both DEPTH_WORDS=256.
//             Vector table plus directed back-to-back and reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_resp;

    logic        clk;
    logic        rst;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] din   [2];
    logic [3:0]  be    [2];
    logic        ack   [2];
    logic [31:0] dout  [2];
    logic        err   [2];
    logic        stall [2];

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    data_memory_resp #(.DEPTH_WORDS(256), .LATENCY(3)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]),
        .addr_i(addr[0]), .data_i(din[0]), .be_i(be[0]),
        .ack_o(ack[0]), .data_o(dout[0]), .err_o(err[0]), .stall_o(stall[0])
    );

    data_memory_resp #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]),
        .addr_i(addr[1]), .data_i(din[1]), .be_i(be[1]),
        .ack_o(ack[1]), .data_o(dout[1]), .err_o(err[1]), .stall_o(stall[1])
    );

    typedef struct {
        int          sel;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One complete transaction on instance s; returns cycles accept->ack.
    task automatic txn(input int s, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b,
                       output int lat, output logic [31:0] rd, output logic er);
        bit done;
        @(negedge clk);
        req[s] = 1'b1; we[s] = w; addr[s] = a; din[s] = d; be[s] = b;
        #1;
        chk("stall_before_accept", 32'(stall[s]), 32'd1);
        lat  = 0;
        done = 1'b0;
        rd   = 32'd0;
        er   = 1'b0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (ack[s]) begin
                done = 1'b1;
                rd   = dout[s];
                er   = err[s];
                chk("stall_in_ack", 32'(stall[s]), 32'd0);
            end else begin
                if (stall[s] !== 1'b1 || err[s] !== 1'b0) begin
                    chk("stall_err_while_waiting", {30'd0, stall[s], err[s]}, 32'd2);
                end
                // Accepted request must be immune to later input changes.
                we[s] = ~w; addr[s] = ~a; din[s] = ~d; be[s] = ~b;
            end
        end
        if (!done) begin
            chk("ack_timeout", 32'd0, 32'd1);
        end
        @(negedge clk);
        req[s] = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;
        int          ack_cnt;
        int          ack_at [2];
        int          any_ack;

        for (int s = 0; s < 2; s++) begin
            req[s] = 1'b0; we[s] = 1'b0; addr[s] = '0; din[s] = '0; be[s] = '0;
        end
        rst = 1'b1;

        //            sel we  addr        data          be       exp_d         exp_e
        tbl[0]  = '{0, 1'b1, 32'h10,  32'hDEADBEEF, 4'b1111, 32'h0,        1'b0};
        tbl[1]  = '{0, 1'b0, 32'h10,  32'h0,        4'b0000, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{0, 1'b1, 32'h20,  32'h11223344, 4'b1111, 32'h0,        1'b0};
        tbl[3]  = '{0, 1'b1, 32'h20,  32'hAABBCCDD, 4'b0101, 32'h0,        1'b0};
        tbl[4]  = '{0, 1'b0, 32'h20,  32'h0,        4'b1111, 32'h11BB33DD, 1'b0};
        tbl[5]  = '{0, 1'b0, 32'h22,  32'h0,        4'b1111, 32'h0,        1'b1};
        tbl[6]  = '{0, 1'b0, 32'h400, 32'h0,        4'b1111, 32'h0,        1'b1};
        tbl[7]  = '{0, 1'b1, 32'h400, 32'h12345678, 4'b1111, 32'h0,        1'b1};
        tbl[8]  = '{0, 1'b1, 32'h13,  32'h99999999, 4'b1111, 32'h0,        1'b1};
        tbl[9]  = '{0, 1'b1, 32'h10,  32'h00000000, 4'b0000, 32'h0,        1'b0};
        tbl[10] = '{0, 1'b0, 32'h10,  32'h0,        4'b0000, 32'hDEADBEEF, 1'b0};
        tbl[11] = '{0, 1'b1, 32'h3FC, 32'hCAFEF00D, 4'b1111, 32'h0,        1'b0};
        tbl[12] = '{0, 1'b0, 32'h3FC, 32'h0,        4'b0000, 32'hCAFEF00D, 1'b0};
        tbl[13] = '{0, 1'b0, 32'h20,  32'h0,        4'b0000, 32'h11BB33DD, 1'b0};
        tbl[14] = '{0, 1'b1, 32'h30,  32'h00000000, 4'b1111, 32'h0,        1'b0};
        tbl[15] = '{1, 1'b1, 32'h40,  32'h01020304, 4'b1111, 32'h0,        1'b0};
        tbl[16] = '{1, 1'b0, 32'h40,  32'h0,        4'b0000, 32'h01020304, 1'b0};
        tbl[17] = '{1, 1'b0, 32'h41,  32'h0,        4'b0000, 32'h0,        1'b1};

        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("reset_ack",   32'(ack[s]),   32'd0);
            chk("reset_err",   32'(err[s]),   32'd0);
            chk("reset_data",  dout[s],       32'd0);
            chk("reset_stall", 32'(stall[s]), 32'd0);
        end
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            txn(tbl[i].sel, tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].be, lat, rd, er);
            chk($sformatf("vec%0d_latency", i), 32'(lat), (tbl[i].sel == 0) ? 32'd3 : 32'd1);
            chk($sformatf("vec%0d_data", i), rd, tbl[i].exp_d);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].exp_e));
        end

        // Back-to-back loads with req held: acks at cycles 3 and 7.
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10; be[0] = 4'b0000;
        ack_cnt = 0;
        ack_at[0] = 0; ack_at[1] = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (stall[0] !== ~ack[0]) begin
                chk($sformatf("b2b_stall_c%0d", k), 32'(stall[0]), 32'(~ack[0]));
            end
            if (ack[0]) begin
                if (ack_cnt < 2) ack_at[ack_cnt] = k;
                ack_cnt++;
                chk("b2b_data", dout[0], 32'hDEADBEEF);
            end
        end
        @(negedge clk);
        req[0] = 1'b0;
        chk("b2b_ack_count", 32'(ack_cnt), 32'd2);
        chk("b2b_first_ack", 32'(ack_at[0]), 32'd3);
        chk("b2b_ack_gap", 32'(ack_at[1] - ack_at[0]), 32'd4);

        // Reset one cycle after accepting a store: aborted, no write.
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h30; din[0] = 32'h55AA55AA; be[0] = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_abort_data", dout[0], 32'd0);
        chk("rst_abort_ack", 32'(ack[0]), 32'd0);
        req[0] = 1'b0;
        any_ack = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (ack[0]) any_ack++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (ack[0]) any_ack++;
        end
        chk("rst_abort_no_ack", 32'(any_ack), 32'd0);
        txn(0, 1'b0, 32'h30, 32'h0, 4'b0000, lat, rd, er);
        chk("rst_abort_latency", 32'(lat), 32'd3);
        chk("rst_abort_mem", rd, 32'h00000000);
        chk("rst_abort_err", 32'(er), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
